// File: rtl/pio_edge_capture_multi.sv
// pio_edge_capture_multi: Avalon-MM input PIO with per-bit synchronisers,
// programmable rise/fall edge capture (W1C) and per-bit edge/level irq.
// Optional build macro: PIO_DEBOUNCE_EN adds a per-bit debounce filter
// between the synchroniser and the edge detector.

// One input bit: synchroniser, optional debounce, edge detect, capture flop.
module pio_edge_lane #(
    parameter int SYNC_STAGES = 2
`ifdef PIO_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    input  logic arm_i,
    input  logic rise_en_i,
    input  logic fall_en_i,
    input  logic clr_i,
    output logic cond_o,
    output logic cap_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   prev_q;
    logic                   cap_q, cap_d;
    logic                   det;

    // shift the raw pin through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    // count consecutive clocks the synchronised level disagrees with the stable one
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync;
            else                                   cnt_d    = cnt_q + 1'b1;
        end
    end

    // debounce state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign cond_o = stable_q;
`else
    assign cond_o = sync;
`endif

    // a set from a fresh edge outranks a simultaneous W1C so no event is lost
    assign det   = arm_i & ((cond_o & ~prev_q & rise_en_i) | (~cond_o & prev_q & fall_en_i));
    assign cap_d = (cap_q & ~clr_i) | det;

    // previous-level and capture flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
            cap_q  <= 1'b0;
        end else begin
            prev_q <= cond_o;
            cap_q  <= cap_d;
        end
    end

    assign cap_o = cap_q;
endmodule

module pio_edge_capture_multi #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    // arm waits until every pipeline stage ahead of the edge detector has filled
`ifdef PIO_DEBOUNCE_EN
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unused_debounce = DEBOUNCE_CYCLES;
`endif
    localparam int ACW = $clog2(ARM_CYCLES + 1);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] cond, cap;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [ACW-1:0]   arm_cnt_q, arm_cnt_d;
    logic             arm_q, arm_d;
    logic [31:0]      readdata_q, readdata_d;

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];
    assign clr   = (wr && address == 3'd3) ? wdata : '0;

    if (WIDTH < 32) begin : g_wd_hi
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        pio_edge_lane #(
            .SYNC_STAGES    (SYNC_STAGES)
`ifdef PIO_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_i      (in_port[i]),
            .arm_i     (arm_q),
            .rise_en_i (rise_en_q[i]),
            .fall_en_i (fall_en_q[i]),
            .clr_i     (clr[i]),
            .cond_o    (cond[i]),
            .cap_o     (cap[i])
        );
    end

    // arm counter: runs once after reset, then arm sticks at 1
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        arm_d     = arm_q;
        if (!arm_q) begin
            if (arm_cnt_q == ACW'(ARM_CYCLES - 1)) arm_d     = 1'b1;
            else                                   arm_cnt_d = arm_cnt_q + 1'b1;
        end
    end

    // RW register writes
    always_comb begin
        rise_en_d = rise_en_q;
        mask_d    = mask_q;
        fall_en_d = fall_en_q;
        level_d   = level_q;
        if (wr) begin
            case (address)
                3'd1:    rise_en_d = wdata;
                3'd2:    mask_d    = wdata;
                3'd4:    fall_en_d = wdata;
                3'd5:    level_d   = wdata;
                default: ;
            endcase
        end
    end

    // read mux, registered every clock regardless of chipselect
    always_comb begin
        case (address)
            3'd0:    readdata_d = 32'(cond);
            3'd1:    readdata_d = 32'(rise_en_q);
            3'd2:    readdata_d = 32'(mask_q);
            3'd3:    readdata_d = 32'(cap);
            3'd4:    readdata_d = 32'(fall_en_q);
            3'd5:    readdata_d = 32'(level_q);
            default: readdata_d = 32'd0;
        endcase
    end

    // register file, arm state and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q  <= '0;
            mask_q     <= '0;
            fall_en_q  <= '0;
            level_q    <= '0;
            arm_cnt_q  <= '0;
            arm_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            rise_en_q  <= rise_en_d;
            mask_q     <= mask_d;
            fall_en_q  <= fall_en_d;
            level_q    <= level_d;
            arm_cnt_q  <= arm_cnt_d;
            arm_q      <= arm_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // level-mode bits contribute their conditioned input, edge-mode bits their capture
    assign irq = |(mask_q & ((level_q & cond) | (~level_q & cap)));
endmodule

// File: tb/tb_pio_edge_capture_multi.sv
// Bench for pio_edge_capture_multi: a history-based model of the conditioned
// inputs and register file, compared against readdata/irq every negedge,
// plus directed vectors with hand-computed literal expectations.
module tb_pio_edge_capture_multi;
    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 16;
`ifdef PIO_DEBOUNCE_EN
    localparam int LAT = S + D;
    localparam int ARM = S + 1 + D;
`else
    localparam int LAT = S;
    localparam int ARM = S + 1;
`endif
    localparam int SETTLE = LAT + 4;
    localparam int MAXE   = 8192;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  readdata;
    logic         irq;

    int n_assert = 0;
    int n_fail   = 0;

    pio_edge_capture_multi #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // n counts clock edges since reset release; samp[k] is in_port at edge k,
    // synch[k]/condh[k] are the synchronised / conditioned level after edge k.
    int           n = 0;
    logic [W-1:0] samp  [MAXE];
    logic [W-1:0] synch [MAXE];
    logic [W-1:0] condh [MAXE];
    logic [W-1:0] m_rise = '0, m_mask = '0, m_cap = '0, m_fall = '0, m_lvl = '0;
    logic [W-1:0] c1, c2, det, clr, t;
    logic         wr;
    logic [31:0]  exp_rd = '0;
    logic         exp_irq = 1'b0;
`ifdef PIO_DEBOUNCE_EN
    int           run [W];
    logic [W-1:0] stab;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = 0;
            synch[0] = '0; condh[0] = '0;
            m_rise = '0; m_mask = '0; m_cap = '0; m_fall = '0; m_lvl = '0;
            exp_rd = '0; exp_irq = 1'b0;
`ifdef PIO_DEBOUNCE_EN
            stab = '0;
            for (int b = 0; b < W; b++) run[b] = 0;
`endif
        end else if (n < MAXE - 1) begin
            n = n + 1;
            samp[n]  = in_port;
            synch[n] = (n >= S) ? samp[n-S+1] : '0;
`ifdef PIO_DEBOUNCE_EN
            t = synch[n-1];
            for (int b = 0; b < W; b++) begin
                if (t[b] != stab[b]) begin
                    run[b] = run[b] + 1;
                    if (run[b] == D) begin stab[b] = t[b]; run[b] = 0; end
                end else run[b] = 0;
            end
            condh[n] = stab;
`else
            t = '0;
            condh[n] = synch[n];
`endif
            c1  = condh[n-1];
            c2  = (n >= 2) ? condh[n-2] : '0;
            det = ((n - 1) >= ARM) ? ((c1 & ~c2 & m_rise) | (~c1 & c2 & m_fall)) : '0;
            wr  = chipselect & ~write_n;
            case (address)
                3'd0:    exp_rd = 32'(c1);
                3'd1:    exp_rd = 32'(m_rise);
                3'd2:    exp_rd = 32'(m_mask);
                3'd3:    exp_rd = 32'(m_cap);
                3'd4:    exp_rd = 32'(m_fall);
                3'd5:    exp_rd = 32'(m_lvl);
                default: exp_rd = 32'd0;
            endcase
            clr   = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
            m_cap = (m_cap & ~clr) | det;
            if (wr) begin
                case (address)
                    3'd1:    m_rise = writedata[W-1:0];
                    3'd2:    m_mask = writedata[W-1:0];
                    3'd4:    m_fall = writedata[W-1:0];
                    3'd5:    m_lvl  = writedata[W-1:0];
                    default: ;
                endcase
            end
            exp_irq = |(m_mask & ((m_lvl & condh[n]) | (~m_lvl & m_cap)));
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fork
            forever begin
                @(negedge clk);
                check("rd_model", readdata, exp_rd);
                check("irq_model", 32'(irq), 32'(exp_irq));
            end
        join_none

        // reset with all inputs high and a RISE_EN=FF write landing on the first edge
        in_port = 8'hFF;
        address = 3'd1; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rd_in_reset", readdata, 32'h0);
        check("irq_in_reset", 32'(irq), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        idle(2 * SETTLE);
        bus_read(3'd3, 32'h00, "cap_after_reset");
        bus_read(3'd0, 32'hFF, "data_after_reset");
        bus_read(3'd1, 32'hFF, "rise_en_first_edge");
        check("irq_after_reset", 32'(irq), 32'h0);

        // rising edge on bit0, exact capture latency, then W1C
        in_port = 8'h00; idle(SETTLE);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h01);
        bus_read(3'd3, 32'h00, "cap_quiet");
        in_port = 8'h01;
        idle(LAT); check("irq_before_capture", 32'(irq), 32'h0);
        idle(1);   check("irq_on_capture", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h01, "cap_rise0");
        bus_write(3'd3, 32'h01);
        check("irq_after_w1c", 32'(irq), 32'h0);
        bus_read(3'd3, 32'h00, "cap_cleared");

        // falling edge on bit7 only
        bus_write(3'd1, 32'h00);
        bus_write(3'd4, 32'h80);
        in_port = 8'h81; idle(SETTLE); bus_read(3'd3, 32'h00, "cap_rise7_ignored");
        in_port = 8'h01; idle(SETTLE); bus_read(3'd3, 32'h80, "cap_fall7");
        in_port = 8'h81; idle(SETTLE); bus_read(3'd3, 32'h80, "cap_fall7_hold");
        check("irq_masked_fall", 32'(irq), 32'h0);
        bus_write(3'd3, 32'hFF);

        // W1C in the same cycle as a new rising edge on bit0: set wins
        bus_write(3'd1, 32'h01);
        in_port = 8'h80; idle(SETTLE);
        in_port = 8'h81; idle(LAT);
        bus_write(3'd3, 32'h01);
        bus_read(3'd3, 32'h01, "cap_set_beats_clear");
        check("irq_set_beats_clear", 32'(irq), 32'h1);
        bus_write(3'd3, 32'hFF);
        check("irq_clr", 32'(irq), 32'h0);

        // level mode on bit2
        bus_write(3'd5, 32'h04);
        bus_write(3'd2, 32'h04);
        bus_write(3'd1, 32'h05);
        in_port = 8'h85;
        idle(LAT - 1); check("irq_lvl_pre", 32'(irq), 32'h0);
        idle(1);       check("irq_lvl_high", 32'(irq), 32'h1);
        idle(SETTLE);  check("irq_lvl_hold", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h04, "cap_lvl_bit2");
        in_port = 8'h81;
        idle(LAT - 1); check("irq_lvl_still", 32'(irq), 32'h1);
        idle(1);       check("irq_lvl_drop", 32'(irq), 32'h0);
        bus_read(3'd3, 32'h04, "cap_lvl_kept");

        // unused addresses and read-only DATA
        bus_write(3'd3, 32'hFF);
        bus_write(3'd6, 32'hFF);
        bus_read(3'd6, 32'h00, "addr6_zero");
        bus_read(3'd7, 32'h00, "addr7_zero");
        bus_write(3'd0, 32'h00);
        bus_read(3'd0, 32'h81, "data_ro");

        // asynchronous reset in the middle of activity
        bus_write(3'd1, 32'hFF);
        in_port = 8'h00; idle(SETTLE);
        in_port = 8'hFF; idle(SETTLE);
        bus_read(3'd3, 32'hFF, "cap_all");
        check("irq_before_reset", 32'(irq), 32'h1);
        #2 reset_n = 1'b0;
        #1 check("rd_async_reset", readdata, 32'h0);
        check("irq_async_reset", 32'(irq), 32'h0);
        @(negedge clk);
        address = 3'd1; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        idle(2 * SETTLE);
        bus_read(3'd3, 32'h00, "cap_after_midreset");
        bus_read(3'd2, 32'h00, "mask_after_midreset");
        bus_read(3'd1, 32'hFF, "rise_en_after_midreset");
        check("irq_after_midreset", 32'(irq), 32'h0);

`ifdef PIO_DEBOUNCE_EN
        // glitch filtering on bit1
        bus_write(3'd1, 32'h02);
        in_port = 8'h00; idle(SETTLE);
        bus_write(3'd3, 32'hFF);
        in_port = 8'h02; idle(5);
        bus_read(3'd0, 32'h00, "deb_data_mid_glitch");
        idle(4);
        in_port = 8'h00; idle(SETTLE);
        bus_read(3'd3, 32'h00, "deb_short_pulse");
        in_port = 8'h02; idle(20);
        in_port = 8'h00; idle(SETTLE);
        bus_read(3'd3, 32'h02, "deb_long_pulse");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
